// File: rtl/display_arbiter_if.sv
// Bundle of request, text and display signals between the text sources
// and the display arbiter.
interface display_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [32*NUM_REQ-1:0] text;
    logic [NUM_REQ-1:0]    grant;
    logic                  busy;
    logic [7:0]            asciiOne;
    logic [7:0]            asciiTwo;
    logic [7:0]            asciiThree;
    logic [7:0]            asciiFour;

    // Text producers drive requests and strings and watch the grant
    modport master (
        output req, text,
        input  grant, busy, asciiOne, asciiTwo, asciiThree, asciiFour
    );

    // The arbiter consumes requests and owns the display outputs
    modport slave (
        input  req, text,
        output grant, busy, asciiOne, asciiTwo, asciiThree, asciiFour
    );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin arbiter that shares a four-character display between up to
// four text sources, holding each grant for a minimum number of cycles so
// messages stay readable. All outputs are registered.
module display_arbiter #(
    parameter int         NUM_REQ     = 4,
    parameter int         HOLD_CYCLES = 50000000,
    parameter logic [7:0] IDLE_CHAR   = 8'h20
) (
    input  logic             CLK,
    input  logic             RESET,
    display_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 2) ? 2 : 1;
    localparam int CW = 26;
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
    localparam logic [31:0]   IDLE_WORD  = {4{IDLE_CHAR}};
    localparam logic [IW-1:0] LAST_RESET = IW'(NUM_REQ - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t             r_state, w_stateNext;
    logic [NUM_REQ-1:0] r_grant, w_grantNext, w_candidates;
    logic [IW-1:0]      r_last, w_lastNext, w_winner;
    logic [CW-1:0]      r_count, w_countNext;
    logic [31:0]        r_ascii, w_asciiNext, w_ownerText, w_winnerText;
    logic               w_found, w_ownerReq, w_holdDone;
    int                 w_idx;

    // The current owner never competes against itself; in IDLE the grant
    // is zero so every request is a candidate.
    assign w_candidates = bus.req & ~r_grant;
    assign w_ownerReq   = |(bus.req & r_grant);
    assign w_holdDone   = (r_count == '0);

    // Round-robin search starting one past the most recent owner
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(r_last) + k) % NUM_REQ;
            if (!w_found && w_candidates[IW'(w_idx)]) begin
                w_found  = 1'b1;
                w_winner = IW'(w_idx);
            end
        end
    end

    // Select the owner's string and the prospective winner's string
    always_comb begin
        w_ownerText  = '0;
        w_winnerText = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == r_last) begin
                w_ownerText = bus.text[32*i +: 32];
            end
            if (IW'(i) == w_winner) begin
                w_winnerText = bus.text[32*i +: 32];
            end
        end
    end

    // Next-state, hold counter and display latch decisions
    always_comb begin
        w_stateNext = r_state;
        w_grantNext = r_grant;
        w_lastNext  = r_last;
        w_countNext = r_count;
        w_asciiNext = r_ascii;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_stateNext = OWN;
                    w_grantNext = NUM_REQ'(1) << w_winner;
                    w_lastNext  = w_winner;
                    w_countNext = HOLD_LOAD;
                    w_asciiNext = w_winnerText;
                end
            end
            OWN: begin
                if (!w_holdDone) begin
                    w_countNext = r_count - 1'b1;
                    if (w_ownerReq) begin
                        w_asciiNext = w_ownerText;
                    end
                end else if (w_found) begin
                    w_grantNext = NUM_REQ'(1) << w_winner;
                    w_lastNext  = w_winner;
                    w_countNext = HOLD_LOAD;
                    w_asciiNext = w_winnerText;
                end else if (w_ownerReq) begin
                    w_asciiNext = w_ownerText;
                end else begin
                    w_stateNext = IDLE;
                    w_grantNext = '0;
                    w_asciiNext = IDLE_WORD;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_grantNext = '0;
                w_asciiNext = IDLE_WORD;
            end
        endcase
    end

    // State and output registers; reset returns to an idle, blank display
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= LAST_RESET;
            r_count <= '0;
            r_ascii <= IDLE_WORD;
        end else begin
            r_state <= w_stateNext;
            r_grant <= w_grantNext;
            r_last  <= w_lastNext;
            r_count <= w_countNext;
            r_ascii <= w_asciiNext;
        end
    end

    assign bus.grant      = r_grant;
    assign bus.busy       = |r_grant;
    assign bus.asciiOne   = r_ascii[31:24];
    assign bus.asciiTwo   = r_ascii[23:16];
    assign bus.asciiThree = r_ascii[15:8];
    assign bus.asciiFour  = r_ascii[7:0];
endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: a behavioural model predicts
// every cycle's outputs into a scoreboard, plus directed checks of the
// key timing points.
module tb_display_arbiter;
    localparam int NUM_REQ = 4;
    localparam int HOLD    = 4;
    localparam logic [31:0] IDLE_WORD = 32'h20202020;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    display_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    display_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .HOLD_CYCLES(HOLD),
        .IDLE_CHAR  (8'h20)
    ) dut (
        .CLK  (clk),
        .RESET(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [3:0]  grant;
        logic        busy;
        logic [31:0] ascii;
    } expect_t;

    expect_t scoreboard[$];
    int compareCount  = 0;
    int mismatchCount = 0;

    bit          mOwning = 1'b0;
    int          mOwner  = 0;
    int          mLast   = NUM_REQ - 1;
    int          mHold   = 0;
    logic [31:0] mShown  = IDLE_WORD;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic int pickNext(input logic [3:0] r, input int from);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(from + k) % NUM_REQ]) return (from + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [31:0] slotOf(input logic [127:0] t, input int i);
        return t[32*i +: 32];
    endfunction

    task automatic modelStep(input logic [3:0] r, input logic [127:0] t, input logic rst);
        int w;
        logic [3:0] others;
        expect_t e;
        if (rst) begin
            mOwning = 1'b0;
            mLast   = NUM_REQ - 1;
            mHold   = 0;
            mShown  = IDLE_WORD;
        end else if (!mOwning) begin
            w = pickNext(r, mLast);
            if (w >= 0) begin
                mOwning = 1'b1;
                mOwner  = w;
                mLast   = w;
                mHold   = HOLD - 1;
                mShown  = slotOf(t, w);
            end
        end else if (mHold > 0) begin
            mHold--;
            if (r[mOwner]) mShown = slotOf(t, mOwner);
        end else begin
            others = r;
            others[mOwner] = 1'b0;
            w = pickNext(others, mOwner);
            if (w >= 0) begin
                mOwner = w;
                mLast  = w;
                mHold  = HOLD - 1;
                mShown = slotOf(t, w);
            end else if (r[mOwner]) begin
                mShown = slotOf(t, mOwner);
            end else begin
                mOwning = 1'b0;
                mShown  = IDLE_WORD;
            end
        end
        e.grant = mOwning ? 4'(1 << mOwner) : 4'b0000;
        e.busy  = mOwning;
        e.ascii = mShown;
        scoreboard.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [127:0] t, input logic rst);
        expect_t e;
        reset    = rst;
        bus.req  = r;
        bus.text = t;
        modelStep(r, t, rst);
        @(posedge clk);
        #1;
        e = scoreboard.pop_front();
        checkOutput("grant", 32'(bus.grant), 32'(e.grant));
        checkOutput("busy", 32'(bus.busy), 32'(e.busy));
        checkOutput("ascii", {bus.asciiOne, bus.asciiTwo, bus.asciiThree, bus.asciiFour}, e.ascii);
    endtask

    function automatic logic [31:0] shown();
        return {bus.asciiOne, bus.asciiTwo, bus.asciiThree, bus.asciiFour};
    endfunction

    // Directed scenarios; the model scoreboard runs underneath every cycle
    initial begin
        logic [127:0] names;
        logic [127:0] liveA;
        logic [127:0] liveB;
        int ownCycles;
        names = {"DDDD", "CCCC", "BBBB", "AAAA"};
        liveA = {"zzzz", "zzzz", "zzzz", "1234"};
        liveB = {"zzzz", "zzzz", "zzzz", "5678"};

        $display("[TB] reset with all requests high");
        applyStimulus(4'b1111, names, 1'b1);
        applyStimulus(4'b1111, names, 1'b1);
        checkOutput("rstGrant", 32'(bus.grant), 32'h0);
        checkOutput("rstBusy", 32'(bus.busy), 32'h0);
        checkOutput("rstAscii", shown(), IDLE_WORD);
        applyStimulus(4'b1111, names, 1'b0);
        checkOutput("firstGrant", 32'(bus.grant), 32'h1);

        $display("[TB] single one-cycle request");
        applyStimulus(4'b0000, names, 1'b1);
        ownCycles = 0;
        for (int j = 0; j < 6; j++) begin
            applyStimulus((j == 0) ? 4'b0100 : 4'b0000, {"zzzz", "ABCD", "zzzz", "zzzz"}, 1'b0);
            if (bus.grant == 4'b0100) ownCycles++;
            if (j == 3) checkOutput("frozenAscii", shown(), 32'h41424344);
        end
        checkOutput("holdLen", 32'(ownCycles), 32'd4);
        checkOutput("idleAscii", shown(), IDLE_WORD);

        $display("[TB] round-robin with all requests held");
        applyStimulus(4'b0000, names, 1'b1);
        for (int j = 0; j < 20; j++) begin
            applyStimulus(4'b1111, names, 1'b0);
            checkOutput("rrGrant", 32'(bus.grant), 32'(1 << ((j / 4) % 4)));
        end

        $display("[TB] live text update");
        applyStimulus(4'b0000, liveA, 1'b1);
        applyStimulus(4'b0001, liveA, 1'b0);
        applyStimulus(4'b0001, liveA, 1'b0);
        checkOutput("liveOld", shown(), 32'h31323334);
        applyStimulus(4'b0001, liveB, 1'b0);
        checkOutput("liveNew", shown(), 32'h35363738);
        checkOutput("liveGrant", 32'(bus.grant), 32'h1);

        $display("[TB] direct handoff");
        applyStimulus(4'b0000, names, 1'b1);
        applyStimulus(4'b1010, names, 1'b0);
        checkOutput("handGrant0", 32'(bus.grant), 32'h2);
        for (int j = 0; j < 3; j++) applyStimulus(4'b1000, names, 1'b0);
        checkOutput("handHeld", 32'(bus.grant), 32'h2);
        checkOutput("handFrozen", shown(), 32'h42424242);
        applyStimulus(4'b1000, names, 1'b0);
        checkOutput("handGrant3", 32'(bus.grant), 32'h8);
        checkOutput("handAscii", shown(), 32'h44444444);

        $display("[TB] reset mid-grant");
        applyStimulus(4'b0000, names, 1'b1);
        applyStimulus(4'b0100, names, 1'b0);
        applyStimulus(4'b0100, names, 1'b0);
        applyStimulus(4'b0100, names, 1'b1);
        checkOutput("midRstGrant", 32'(bus.grant), 32'h0);
        checkOutput("midRstAscii", shown(), IDLE_WORD);
        applyStimulus(4'b0101, names, 1'b0);
        checkOutput("postRstGrant", 32'(bus.grant), 32'h1);
        for (int j = 0; j < 6; j++) applyStimulus(4'b0101, names, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule

// File: doc/display_arbiter.md
# display_arbiter

Shares the four-character seven-segment display between up to four independent text sources. Each source presents a four-character ASCII string with a request. The block grants the display round-robin and enforces a minimum on-screen hold time, so no message flickers past unread. It sits between the text producers (scrollers, status generators) and the ASCII-to-segment decoder, and drives that decoder's four ASCII character inputs directly.

## Interface
Parameters:
- NUM_REQ, default 4: number of requesters, legal range 2..4.
- HOLD_CYCLES, default 50000000: minimum clock cycles a grant is held. Legal range 1..2^26; 50000000 is 1 s at 50 MHz.
- IDLE_CHAR, default 8'h20: ASCII code shown on all four digits when nobody holds the display.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- req  in  NUM_REQ  request per source; level-sensitive.
- text  in  32*NUM_REQ  four ASCII characters per source.
  - Source i occupies bits [32i+31:32i].
  - Bits [32i+31:32i+24] are the leftmost character; bits [32i+7:32i] are the rightmost.
- grant  out  NUM_REQ  one-hot current owner; all-zero when idle.
- busy  out  1  high whenever grant is nonzero.
- asciiOne / asciiTwo / asciiThree / asciiFour  out  8 each  displayed characters, leftmost to rightmost.

## Operation
State machine, two states.

IDLE:
- grant = 0, busy = 0, all ascii outputs = IDLE_CHAR.
- If any req bit is high, select a winner and move to OWN.

OWN:
- Exactly one grant bit is high.
- On entry, the hold counter loads HOLD_CYCLES-1.
- The counter decrements once per cycle and saturates at 0. The hold is satisfied when the counter is 0.

Winner selection (round-robin):
- Search starts at index (last+1) mod NUM_REQ, where `last` is the most recent owner.
- The first index with req high wins.
- The `last` pointer updates only when a grant is issued.
- Reset value of `last` is NUM_REQ-1, so source 0 wins first after reset.

Display latch:
- While the owner's req is high, ascii outputs register the owner's text every cycle, so live text changes pass through.
- If the owner drops req before the hold is satisfied, the outputs freeze at the last latched text and the grant remains until the hold is satisfied.

Release and switch rules, evaluated only when the hold is satisfied:
- Owner req low, no other req: go to IDLE.
- Owner req low, another req high: switch directly to the round-robin winner, with no IDLE cycle. Reload the counter.
- Owner req high, another req high: time-slice. Switch to the round-robin winner and reload the counter.
- Owner req high, no other req: stay in OWN with the counter held at 0. A new request arriving later causes a switch on the next decision.

Boundary conditions:
- HOLD_CYCLES = 1: the counter loads 0, so the hold is satisfied on the first OWN cycle. With contention, the owner changes every cycle.
- Requests that rise and fall while another source owns the display are never seen. No request memory is kept.
- Only bits below NUM_REQ exist; there are no unused requesters.
- RESET asserted mid-grant: next cycle returns to IDLE with grant = 0, busy = 0, outputs = IDLE_CHAR, `last` = NUM_REQ-1, counter = 0. RESET overrides every other input.

## Timing
- All outputs are registered, and grant, busy and ascii change on the same edge.
- IDLE with req[i] high at edge t: grant[i], busy and ascii (equal to text_i sampled at t) are valid after edge t+1. Latency is 1 cycle.
- A grant issued at edge t is held through at least HOLD_CYCLES edges. The earliest change is at edge t+HOLD_CYCLES.
- Owner text change at edge t appears on ascii after edge t+1.
- A switch replaces grant and ascii in one edge, with no IDLE_CHAR gap.
- Worst-case wait for a continuously requesting source is (NUM_REQ-1)*HOLD_CYCLES + 1 cycles.

## Test plan
Run with NUM_REQ=4 and HOLD_CYCLES=4 unless stated.

1. Reset: hold RESET 2 cycles with all req high -> grant=0000, busy=0, ascii=20,20,20,20. After release, the first grant is 0001 one cycle later.
2. Single source: req[2] pulses high for 1 cycle with text "ABCD" -> grant=0100 for exactly 4 cycles, ascii=41,42,43,44 frozen, then IDLE with ascii=20.
3. Round-robin: req = 1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001, each lasting exactly 4 cycles, with no IDLE cycles between.
4. Live text: owner 0 changes text "1234" to "5678" mid-hold -> ascii reflects "5678" one cycle later, and the grant is unchanged.
5. Direct handoff: req[1] drops at cycle 1 of hold while req[3] is high -> grant moves 0010 to 1000 exactly at hold expiry. ascii switches the same edge.
6. Reset mid-grant: RESET during OWN of source 2 -> next cycle IDLE. With req = 0101 afterwards, the next grant is 0001, not 0100.
